mandel_pixel_scheduler: RTL and testbench
=========================================

// Module: mandel_pixel_scheduler
// PURPOSE
//  Frame-level controller for a bank of N_ITER mandelbrot iterators.
//  - Walks the screen raster and computes each pixel's cr/ci incrementally (4.23 fixed point).
//  - Dispatches each pixel to a free iterator and collects the escape count once flag rises.
//  - Emits {address, count} pairs on a valid/ready port toward the colour-map/VGA SRAM writer.
//  - Sits between the HPS parameter registers and the iterator bank.
// PARAMETERS
//  N_ITER   6    number of iterator slots
//  WIDTH    640  pixels per line
//  HEIGHT   480  lines per frame
//  FIX_W    27   fixed-point width, 4.23 two's complement
//  ADDR_W   32   pixel address width
// PORTS
//  clk          in   1             system clock
//  reset        in   1             async, active-high
//  start        in   1             begin a frame; sampled in IDLE/DONE only
//  cr_min       in   FIX_W         cr of column 0
//  ci_max       in   FIX_W         ci of line 0
//  dcr          in   FIX_W         cr step per column
//  dci          in   FIX_W         ci step per line (subtracted)
//  it_reset     out  N_ITER        per-slot iterator reset, active-high
//  it_cr        out  N_ITER*FIX_W  per-slot cr, slot i at [i*FIX_W +: FIX_W]
//  it_ci        out  N_ITER*FIX_W  per-slot ci, same packing
//  it_flag      in   N_ITER        per-slot "finished" from iterator
//  it_n         in   N_ITER*FIX_W  per-slot iteration count
//  pix_valid    out  1             result available
//  pix_ready    in   1             downstream accepts
//  pix_addr     out  ADDR_W        linear address y*WIDTH+x
//  pix_n        out  FIX_W         escape count of that pixel
//  busy         out  1             frame in progress
//  done         out  1             frame complete; held until next start
//  frame_cycles out  32            clk cycles from start to done
// BEHAVIOUR
//  Reset values: it_reset all 1, it_cr/it_ci 0, pix_valid 0, pix_addr 0, pix_n 0,
//   busy 0, done 0, frame_cycles 0. Reset mid-frame aborts immediately and returns to IDLE.
//  FSM states: IDLE -> INIT -> RUN -> DRAIN -> DONE.
//   - IDLE/DONE + start -> INIT. start in any other state is ignored.
//   - INIT (1 cycle): x=y=0, addr=0, cr_cur=cr_min, ci_cur=ci_max; all slots FREE.
//     busy=1, done=0, frame_cycles cleared.
//   - RUN -> DRAIN in the cycle the last pixel (addr WIDTH*HEIGHT-1) is dispatched.
//   - DRAIN -> DONE when all slots are FREE and pix_valid=0. DONE: busy=0, done=1.
//  Coordinate stepping:
//   - Each dispatch advances x and sets cr_cur+=dcr, addr+=1.
//   - At x==WIDTH-1: x=0, cr_cur=cr_min, y+=1, ci_cur-=dci.
//   - No multiplier; additions wrap at FIX_W bits.
//  Slot lifecycle: FREE -> LOAD -> RUN -> HELD -> FREE.
//   - FREE: it_reset=1.
//   - Dispatch: at most one per cycle, to the lowest-index FREE slot.
//     Latches cr_cur/ci_cur/addr into that slot, which enters LOAD with it_reset still 1.
//   - Next cycle: it_reset=0, slot enters RUN.
//   - RUN with it_flag=1 -> HELD.
//  Output (one-entry register):
//   - When pix_valid=0 and any slot is HELD, select one by the configured policy.
//   - Load pix_addr/pix_n from that slot and set pix_valid=1.
//   - pix_addr/pix_n are stable while pix_valid && !pix_ready.
//   - On pix_valid && pix_ready: the selected slot goes FREE (it_reset=1 next cycle).
//     pix_valid drops unless another HELD slot is loaded in that same cycle.
//  Same-cycle events:
//   - A slot freed this cycle is not redispatched until the next cycle.
//   - A dispatch and a result capture may occur in the same cycle on different slots.
//  frame_cycles increments every cycle in INIT/RUN/DRAIN and freezes in DONE.
//  Latency: start at cycle 0 -> INIT at 1 -> slot 0 LOAD at 2 -> it_reset[0]=0 at 3.
// CONFIGURATION
//  MANDEL_SCHED_RR_EN
//   - defined: round-robin among HELD slots. The search starts one above the last
//     granted index and wraps at N_ITER-1 -> 0.
//   - undefined: fixed priority, lowest HELD index wins.
// STRUCTURE
//  mandel_pkg: FIX_W, 4.23 constants (ONE, TWO, FOUR), FSM state and slot-state encodings.
//  Sub-module mandel_coord_gen: x/y/addr counters and cr_cur/ci_cur stepping.
//   Inputs: advance, init. Output: last_pixel.
// TESTING (WIDTH=4, HEIGHT=2, N_ITER=2 unless noted)
//  1 Assert reset at any time -> it_reset=2'b11, pix_valid=0, busy=0, done=0, frame_cycles=0.
//  2 Iterator model flags 3 cycles after release, pix_ready=1 -> addrs 0..7 each exactly once;
//    done=1, busy=0; frame_cycles matches the model cycle count.
//  3 cr_min=-2.0 (27'h7000000), dcr=0.5, ci_max=1.0, dci=0.25 -> pixel addr 7 was
//    dispatched with cr=-0.5, ci=0.75.
//  4 pix_ready=0 for 20 cycles while both slots HELD -> pix_valid held, addr/n unchanged,
//    no dispatch occurs.
//  5 Slots 0 and 1 flag in the same cycle, repeatedly -> with MANDEL_SCHED_RR_EN grants
//    alternate 0,1,0,1; without it slot 0 is always first.
//  6 reset pulsed mid-RUN at addr 3, then start -> clean restart; full 0..7 sequence, done=1.

Source files
------------

// File: rtl/mandel_pkg.sv
// mandel_pkg: fixed-point constants and state encodings shared by
// the mandelbrot pixel scheduler and its coordinate generator.
package mandel_pkg;

   localparam int FIX_W  = 27;
   localparam int FRAC_W = 23;

   // 4.23 two's complement constants
   localparam logic [FIX_W-1:0] ONE  = 27'h0800000;
   localparam logic [FIX_W-1:0] TWO  = 27'h1000000;
   localparam logic [FIX_W-1:0] FOUR = 27'h2000000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      SL_FREE,
      SL_LOAD,
      SL_RUN,
      SL_HELD
   } slot_t;

endpackage

// File: rtl/mandel_coord_gen.sv
// mandel_coord_gen: raster walk (x, y, linear address) with
// incremental cr/ci stepping; additions wrap at FIX_W bits.
module mandel_coord_gen #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int FIX_W  = 27,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic              advance,
   input  logic [FIX_W-1:0]  cr_min,
   input  logic [FIX_W-1:0]  ci_max,
   input  logic [FIX_W-1:0]  dcr,
   input  logic [FIX_W-1:0]  dci,
   output logic [FIX_W-1:0]  cr_cur,
   output logic [FIX_W-1:0]  ci_cur,
   output logic [ADDR_W-1:0] addr,
   output logic              last_pixel
);
   import mandel_pkg::*;

   localparam int XW = $clog2(WIDTH + 1);
   localparam int YW = $clog2(HEIGHT + 1);

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          x_end;

   assign x_end      = (x == XW'(WIDTH - 1));
   assign last_pixel = x_end && (y == YW'(HEIGHT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x      <= '0;
         y      <= '0;
         addr   <= '0;
         cr_cur <= '0;
         ci_cur <= '0;
      end else if (init) begin
         x      <= '0;
         y      <= '0;
         addr   <= '0;
         cr_cur <= cr_min;
         ci_cur <= ci_max;
      end else if (advance) begin
         addr <= addr + ADDR_W'(1);
         if (x_end) begin
            x      <= '0;
            y      <= y + YW'(1);
            cr_cur <= cr_min;
            ci_cur <= ci_cur - dci;
         end else begin
            x      <= x + XW'(1);
            cr_cur <= cr_cur + dcr;
         end
      end
   end

endmodule

// File: rtl/mandel_pixel_scheduler.sv
// mandel_pixel_scheduler: dispatches raster pixels to an iterator bank
// and streams {addr, count} results. Option: MANDEL_SCHED_RR_EN.
module mandel_pixel_scheduler #(
   parameter int N_ITER = 6,
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int FIX_W  = 27,
   parameter int ADDR_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [FIX_W-1:0]        cr_min,
   input  logic [FIX_W-1:0]        ci_max,
   input  logic [FIX_W-1:0]        dcr,
   input  logic [FIX_W-1:0]        dci,
   output logic [N_ITER-1:0]       it_reset,
   output logic [N_ITER*FIX_W-1:0] it_cr,
   output logic [N_ITER*FIX_W-1:0] it_ci,
   input  logic [N_ITER-1:0]       it_flag,
   input  logic [N_ITER*FIX_W-1:0] it_n,
   output logic                    pix_valid,
   input  logic                    pix_ready,
   output logic [ADDR_W-1:0]       pix_addr,
   output logic [FIX_W-1:0]        pix_n,
   output logic                    busy,
   output logic                    done,
   output logic [31:0]             frame_cycles
);
   import mandel_pkg::*;

   localparam int IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

   state_t state, state_nx;

   slot_t             sst    [N_ITER];
   logic [FIX_W-1:0]  s_cr   [N_ITER];
   logic [FIX_W-1:0]  s_ci   [N_ITER];
   logic [ADDR_W-1:0] s_addr [N_ITER];
   logic [FIX_W-1:0]  n_arr  [N_ITER];

   logic [N_ITER-1:0] free_v;
   logic [N_ITER-1:0] cand_v;
   logic [IW-1:0]     dsp_idx;
   logic [IW-1:0]     ld_idx;
   logic [IW-1:0]     sel;

   logic start_ok;
   logic dsp_ok;
   logic load;
   logic take;
   logic last_pixel;

   logic [FIX_W-1:0]  cr_cur;
   logic [FIX_W-1:0]  ci_cur;
   logic [ADDR_W-1:0] addr_cur;

   mandel_coord_gen #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .FIX_W  (FIX_W),
      .ADDR_W (ADDR_W)
   ) u_coord (
      .clk        (clk),
      .reset      (reset),
      .init       (start_ok),
      .advance    (dsp_ok),
      .cr_min     (cr_min),
      .ci_max     (ci_max),
      .dcr        (dcr),
      .dci        (dci),
      .cr_cur     (cr_cur),
      .ci_cur     (ci_cur),
      .addr       (addr_cur),
      .last_pixel (last_pixel)
   );

   for (genvar g = 0; g < N_ITER; g++) begin : g_pack
      assign it_cr[g*FIX_W +: FIX_W] = s_cr[g];
      assign it_ci[g*FIX_W +: FIX_W] = s_ci[g];
      assign n_arr[g] = it_n[g*FIX_W +: FIX_W];
   end

   // The slot parked in the output register stays HELD but is no
   // longer a candidate for the next load.
   always_comb begin
      free_v   = '0;
      cand_v   = '0;
      it_reset = '0;
      for (int i = 0; i < N_ITER; i++) begin
         free_v[i]   = (sst[i] == SL_FREE);
         cand_v[i]   = (sst[i] == SL_HELD) &&
                       !(pix_valid && sel == IW'(i));
         it_reset[i] = (sst[i] == SL_FREE) ||
                       (sst[i] == SL_LOAD);
      end
   end

   always_comb begin
      dsp_idx = '0;
      for (int i = N_ITER - 1; i >= 0; i--) begin
         if (free_v[i]) dsp_idx = IW'(i);
      end
   end

   always_comb begin
      ld_idx = '0;
`ifdef MANDEL_SCHED_RR_EN
      // walk downward so the nearest index above sel wins
      for (int k = N_ITER; k >= 1; k--) begin
         if (cand_v[(int'(sel) + k) % N_ITER])
            ld_idx = IW'((int'(sel) + k) % N_ITER);
      end
`else
      for (int i = N_ITER - 1; i >= 0; i--) begin
         if (cand_v[i]) ld_idx = IW'(i);
      end
`endif
   end

   assign start_ok = start &&
                     (state == S_IDLE || state == S_DONE);
   assign dsp_ok   = (state == S_INIT || state == S_RUN) &&
                     (|free_v);
   assign take     = pix_valid && pix_ready;
   assign load     = (!pix_valid || pix_ready) && (|cand_v);

   assign busy = (state == S_INIT) || (state == S_RUN) ||
                 (state == S_DRAIN);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) state_nx = S_INIT;
         end
         S_INIT, S_RUN: begin
            if (dsp_ok && last_pixel) state_nx = S_DRAIN;
            else                      state_nx = S_RUN;
         end
         S_DRAIN: begin
            if ((&free_v) && !pix_valid) state_nx = S_DONE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_ITER; i++) begin
            sst[i]    <= SL_FREE;
            s_cr[i]   <= '0;
            s_ci[i]   <= '0;
            s_addr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_ITER; i++) begin
            unique case (sst[i])
               SL_FREE: begin
                  if (dsp_ok && dsp_idx == IW'(i)) begin
                     sst[i]    <= SL_LOAD;
                     s_cr[i]   <= cr_cur;
                     s_ci[i]   <= ci_cur;
                     s_addr[i] <= addr_cur;
                  end
               end
               SL_LOAD: sst[i] <= SL_RUN;
               SL_RUN: begin
                  if (it_flag[i]) sst[i] <= SL_HELD;
               end
               SL_HELD: begin
                  if (take && sel == IW'(i)) sst[i] <= SL_FREE;
               end
               default: sst[i] <= SL_FREE;
            endcase
         end
      end
   end

   // sel doubles as the last granted index for round-robin
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_valid <= 1'b0;
         pix_addr  <= '0;
         pix_n     <= '0;
         sel       <= IW'(N_ITER - 1);
      end else if (load) begin
         pix_valid <= 1'b1;
         pix_addr  <= s_addr[ld_idx];
         pix_n     <= n_arr[ld_idx];
         sel       <= ld_idx;
      end else if (take) begin
         pix_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         frame_cycles <= '0;
      else if (start_ok) frame_cycles <= '0;
      else if (busy)     frame_cycles <= frame_cycles + 32'd1;
   end

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// tb_mandel_pixel_scheduler: table-driven frames plus hand-written
// stall, grant-order and mid-frame reset sequences.
module tb_mandel_pixel_scheduler;

   localparam int N  = 2;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int FW = 27;
   localparam int AW = 32;
   localparam int NP = W * H;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [FW-1:0]   cr_min = '0;
   logic [FW-1:0]   ci_max = '0;
   logic [FW-1:0]   dcr = '0;
   logic [FW-1:0]   dci = '0;
   logic [N-1:0]    it_reset;
   logic [N*FW-1:0] it_cr;
   logic [N*FW-1:0] it_ci;
   logic [N-1:0]    it_flag = '0;
   logic [N*FW-1:0] it_n = '0;
   logic            pix_valid;
   logic            pix_ready = 1'b0;
   logic [AW-1:0]   pix_addr;
   logic [FW-1:0]   pix_n;
   logic            busy;
   logic            done;
   logic [31:0]     frame_cycles;

   mandel_pixel_scheduler #(
      .N_ITER (N),
      .WIDTH  (W),
      .HEIGHT (H),
      .FIX_W  (FW),
      .ADDR_W (AW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .cr_min       (cr_min),
      .ci_max       (ci_max),
      .dcr          (dcr),
      .dci          (dci),
      .it_reset     (it_reset),
      .it_cr        (it_cr),
      .it_ci        (it_ci),
      .it_flag      (it_flag),
      .it_n         (it_n),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_addr     (pix_addr),
      .pix_n        (pix_n),
      .busy         (busy),
      .done         (done),
      .frame_cycles (frame_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [FW-1:0] cr_min;
      logic [FW-1:0] ci_max;
      logic [FW-1:0] dcr;
      logic [FW-1:0] dci;
      int            delay;
      int            rmode;
      logic [FW-1:0] cr7;
      logic [FW-1:0] ci7;
   } vec_t;

   typedef struct {
      int            addr;
      logic [FW-1:0] n;
   } res_t;

   vec_t vecs [3];
   res_t exp_q [$];
   int   grant_q [$];

   int n_pass = 0;
   int n_total = 0;

   int            delay = 3;
   int            rmode = 0;
   bit            hold = 1'b0;
   int            cnt [N];
   int            slot_a [N];
   logic [N-1:0]  prev_rst = '1;
   int            next_addr = 0;
   int            busy_cnt = 0;
   int            out_cnt = 0;
   logic [FW-1:0] cr_last = '0;
   logic [FW-1:0] ci_last = '0;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [FW-1:0] exp_cr(input int a);
      return FW'(cr_min + dcr * (a % W));
   endfunction

   function automatic logic [FW-1:0] exp_ci(input int a);
      return FW'(ci_max - dci * (a / W));
   endfunction

   task automatic clear_model();
      next_addr = 0;
      busy_cnt  = 0;
      out_cnt   = 0;
      prev_rst  = '1;
      it_flag   = '0;
      exp_q.delete();
      grant_q.delete();
      for (int i = 0; i < N; i++) begin
         cnt[i]    = 0;
         slot_a[i] = -1;
      end
   endtask

   // one clock: observe dispatches/results, drive ready and iterators
   task automatic tick();
      int            a;
      int            hit;
      int            gs;
      logic [FW-1:0] nv;
      @(negedge clk);
      if (busy) busy_cnt++;
      for (int i = 0; i < N; i++) begin
         if (prev_rst[i] && !it_reset[i]) begin
            a = next_addr;
            slot_a[i] = a;
            chk($sformatf("cr_addr%0d", a), it_cr[i*FW +: FW], exp_cr(a));
            chk($sformatf("ci_addr%0d", a), it_ci[i*FW +: FW], exp_ci(a));
            if (a == NP - 1) begin
               cr_last = it_cr[i*FW +: FW];
               ci_last = it_ci[i*FW +: FW];
            end
            next_addr++;
         end
         prev_rst[i] = it_reset[i];
      end
      case (rmode)
         0:       pix_ready = 1'b1;
         1:       pix_ready = 1'($urandom_range(0, 1));
         default: pix_ready = 1'b0;
      endcase
      if (pix_valid && pix_ready) begin
         hit = -1;
         foreach (exp_q[k])
            if (hit < 0 && exp_q[k].addr == int'(pix_addr)) hit = k;
         if (hit < 0) begin
            n_total++;
            $display("FAIL out_addr: got unexpected addr %0d", pix_addr);
         end else begin
            chk($sformatf("out_n_addr%0d", pix_addr), pix_n, exp_q[hit].n);
            exp_q.delete(hit);
         end
         out_cnt++;
         gs = -1;
         for (int i = 0; i < N; i++)
            if (slot_a[i] == int'(pix_addr)) gs = i;
         grant_q.push_back(gs);
      end
      for (int i = 0; i < N; i++) begin
         if (it_reset[i]) begin
            cnt[i]     = 0;
            it_flag[i] = 1'b0;
         end else if (!it_flag[i]) begin
            if (cnt[i] < delay) cnt[i]++;
            if (cnt[i] >= delay && !hold) begin
               it_flag[i] = 1'b1;
               nv = FW'(slot_a[i] * 37 + 5);
               it_n[i*FW +: FW] = nv;
               exp_q.push_back('{slot_a[i], nv});
            end
         end
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk({tag, "_it_reset"}, it_reset, 2'b11);
      chk({tag, "_it_cr"}, it_cr, '0);
      chk({tag, "_it_ci"}, it_ci, '0);
      chk({tag, "_pix_valid"}, pix_valid, 0);
      chk({tag, "_pix_addr"}, pix_addr, 0);
      chk({tag, "_pix_n"}, pix_n, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_frame_cycles"}, frame_cycles, 0);
      @(negedge clk);
      reset = 1'b0;
      clear_model();
   endtask

   task automatic load_vec(input int v);
      cr_min = vecs[v].cr_min;
      ci_max = vecs[v].ci_max;
      dcr    = vecs[v].dcr;
      dci    = vecs[v].dci;
      delay  = vecs[v].delay;
      rmode  = vecs[v].rmode;
   endtask

   task automatic start_frame();
      clear_model();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic finish_frame(input string tag, input int v);
      for (int c = 0; c < 3000 && !done; c++) tick();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_frame_cycles"}, frame_cycles, busy_cnt);
      chk({tag, "_dispatched"}, next_addr, NP);
      chk({tag, "_outputs"}, out_cnt, NP);
      chk({tag, "_pending"}, exp_q.size(), 0);
      chk({tag, "_cr_last"}, cr_last, vecs[v].cr7);
      chk({tag, "_ci_last"}, ci_last, vecs[v].ci7);
   endtask

   initial begin
      int bv;
      int bs;
      int bd;
      int ok;
      logic [AW-1:0] a0;
      logic [FW-1:0] n0;

      vecs[0] = '{27'h7000000, 27'h0800000, 27'h0400000, 27'h0200000,
                  3, 0, 27'h7C00000, 27'h0600000};
      vecs[1] = '{27'h0000000, 27'h0000000, 27'h0000001, 27'h0000001,
                  2, 1, 27'h0000003, 27'h7FFFFFF};
      vecs[2] = '{27'h3FFFFFF, 27'h4000000, 27'h0000001, 27'h0000001,
                  1, 0, 27'h4000002, 27'h3FFFFFF};

      clear_model();
      do_reset("rst");

      for (int v = 0; v < 3; v++) begin
         load_vec(v);
         start_frame();
         finish_frame($sformatf("frame%0d", v), v);
      end

      // downstream stall with both slots holding results
      load_vec(0);
      rmode = 2;
      start_frame();
      ok = 0;
      for (int c = 0; c < 200 && ok == 0; c++) begin
         tick();
         if (pix_valid && it_flag == 2'b11 && it_reset == 2'b00) ok = 1;
      end
      chk("stall_reached", ok, 1);
      tick();
      a0 = pix_addr;
      n0 = pix_n;
      bv = 0;
      bs = 0;
      bd = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (!pix_valid) bv++;
         if (pix_addr !== a0 || pix_n !== n0) bs++;
         if (it_reset !== 2'b00) bd++;
      end
      chk("stall_valid_drops", bv, 0);
      chk("stall_data_moves", bs, 0);
      chk("stall_dispatches", bd, 0);
      rmode = 0;
      finish_frame("stall", 0);

      // simultaneous flags: grant order per round is slot 0 then 1
      do_reset("rst_rr");
      load_vec(0);
      hold = 1'b1;
      start_frame();
      for (int r = 0; r < NP / 2; r++) begin
         ok = 0;
         for (int c = 0; c < 200 && ok == 0; c++) begin
            tick();
            ok = 1;
            for (int i = 0; i < N; i++)
               if (cnt[i] < delay || it_reset[i] || it_flag[i]) ok = 0;
         end
         chk($sformatf("pair%0d_ready", r), ok, 1);
         hold = 1'b0;
         tick();
         hold = 1'b1;
         for (int c = 0; c < 200 && grant_q.size() < 2 * (r + 1); c++)
            tick();
         chk($sformatf("pair%0d_first", r),
             grant_q.size() > 2 * r ? grant_q[2*r] : -1, 0);
         chk($sformatf("pair%0d_second", r),
             grant_q.size() > 2 * r + 1 ? grant_q[2*r+1] : -1, 1);
      end
      hold = 1'b0;
      finish_frame("pairs", 0);

      // reset mid-frame, then a clean full frame
      load_vec(0);
      start_frame();
      for (int c = 0; c < 200 && next_addr < 4; c++) tick();
      chk("mid_addr3_seen", next_addr >= 4, 1);
      do_reset("rst_mid");
      start_frame();
      finish_frame("restart", 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
